// File: rtl/fifo_win_pkg.sv
// Shared types for the line-buffer window read sequencer.
// Field widths below follow the sequencer's default parameters.
package fifo_win_pkg;

    localparam int KMAX  = 7;
    localparam int KW    = $clog2(KMAX + 1);
    localparam int TW    = $clog2(KMAX);
    localparam int PIXW  = 10;
    localparam int REPW  = 4;
    localparam int DATAW = 16 * 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [TW-1:0]    tap;
        logic             lastpix;
    } ent_t;

    typedef struct packed {
        logic [KW-1:0]   k;
        logic [PIXW-1:0] pix;
        logic [REPW-1:0] rep;
    } cfg_t;

endpackage

// File: rtl/fifo_win_skidbuf.sv
// Two-entry rdy/ack buffer; the count is exposed so the
// sequencer can hold back reads it has no room to absorb.
module fifo_win_skidbuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         rdy,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         wp;
    logic         rp;
    logic         take;

    assign take = pop && (cnt != 2'd0);
    assign rdy  = (cnt != 2'd0);
    assign dout = rp ? e1 : e0;

    always_ff @(posedge clk) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                if (wp) e1 <= din;
                else    e0 <= din;
                wp <= ~wp;
            end
            if (take) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, take};
        end
    end

endmodule

// File: rtl/fifo_win_rdseq.sv
// Sliding-window read sequencer for the line-buffer FIFO.
// Optional stall counter: define LPACCEL_WINSEQ_PERF_EN.
module fifo_win_rdseq
    import fifo_win_pkg::*;
#(
    parameter int Size   = 12,
    parameter int DWd    = 16,
    parameter int InsNum = 16,
    parameter int KMax   = KMAX,
    parameter int PixWd  = PIXW,
    parameter int RepWd  = REPW,
    parameter int OWd    = $clog2(Size + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cfg_rdy,
    output logic                      o_cfg_ack,
    input  logic [$clog2(KMax+1)-1:0] i_cfg_k,
    input  logic [PixWd-1:0]          i_cfg_pix,
    input  logic [RepWd-1:0]          i_cfg_rep,
    input  logic                      i_fifo_wr,
    output logic                      o_fifo_full,
    output logic                      o_read,
    output logic                      o_pop,
    output logic                      o_lastpix,
    input  logic [InsNum*DWd-1:0]     i_rdata,
    input  logic                      i_rvalid,
    output logic                      o_dst_rdy,
    input  logic                      i_dst_ack,
    output logic [InsNum*DWd-1:0]     o_dst_data,
    output logic [$clog2(KMax)-1:0]   o_dst_tap,
    output logic                      o_dst_lastpix,
`ifdef LPACCEL_WINSEQ_PERF_EN
    output logic [31:0]               o_stall_cnt,
`endif
    output logic                      o_busy
);

    state_t           state;
    state_t           state_n;
    cfg_t             cfg;
    logic [OWd-1:0]   occ;
    logic [TW-1:0]    tap;
    logic [RepWd-1:0] rep;
    logic [PixWd-1:0] pix;
    logic [KW-1:0]    drn;

    logic             inflight;
    logic             discard;
    logic [TW-1:0]    tap_q;
    logic             last_q;

    logic             issue;
    logic             accept;
    logic             last_tap;
    logic             last_rep;
    logic             last_pix;
    logic             room;
    logic             credit_ok;
    logic             row_end;
    logic [1:0]       cnt;
    ent_t             ent_in;
    ent_t             ent_out;

    assign last_tap  = (tap == TW'(cfg.k - KW'(1)));
    assign last_rep  = (rep == cfg.rep - RepWd'(1));
    assign last_pix  = (pix == cfg.pix - PixWd'(1));
    assign room      = (occ >= OWd'(cfg.k));
    // Buffered entries plus the read still in flight must stay below two.
    assign credit_ok = (cnt == 2'd0) || ((cnt == 2'd1) && !inflight);
    assign row_end   = o_pop && last_pix && (state == RUN);

    always_comb begin
        state_n   = state;
        o_read    = 1'b0;
        o_pop     = 1'b0;
        o_lastpix = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_cfg_rdy) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                issue     = room && credit_ok;
                o_read    = issue;
                o_lastpix = issue && last_tap;
                o_pop     = issue && last_tap && last_rep;
                if (o_pop && last_pix)
                    state_n = (cfg.k > KW'(1)) ? DRAIN : IDLE;
            end
            DRAIN: begin
                o_read    = 1'b1;
                o_pop     = 1'b1;
                o_lastpix = 1'b1;
                if (drn == KW'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cfg      <= '0;
            occ      <= '0;
            tap      <= '0;
            rep      <= '0;
            pix      <= '0;
            drn      <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            tap_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            occ      <= occ + OWd'(i_fifo_wr) - OWd'(o_pop);
            inflight <= issue;
            discard  <= (state == DRAIN);
            tap_q    <= tap;
            last_q   <= row_end;
            if (accept) begin
                cfg <= '{k: i_cfg_k, pix: i_cfg_pix, rep: i_cfg_rep};
                tap <= '0;
                rep <= '0;
                pix <= '0;
            end
            if (issue) begin
                tap <= last_tap ? '0 : tap + TW'(1);
                if (last_tap) begin
                    if (last_rep) begin
                        rep <= '0;
                        pix <= pix + PixWd'(1);
                    end else begin
                        rep <= rep + RepWd'(1);
                    end
                end
            end
            if (row_end)
                drn <= cfg.k - KW'(1);
            else if (state == DRAIN)
                drn <= drn - KW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(i_fifo_wr && o_fifo_full));
    end

    assign ent_in = '{data: i_rdata, tap: tap_q, lastpix: last_q};

    fifo_win_skidbuf #(
        .W($bits(ent_t))
    ) u_skid (
        .clk  (i_clk),
        .rst  (i_rst),
        .push (i_rvalid && !discard),
        .din  (ent_in),
        .pop  (i_dst_ack),
        .rdy  (o_dst_rdy),
        .dout (ent_out),
        .cnt  (cnt)
    );

    assign o_dst_data    = ent_out.data;
    assign o_dst_tap     = ent_out.tap;
    assign o_dst_lastpix = ent_out.lastpix;
    assign o_cfg_ack     = accept && !i_rst;
    assign o_fifo_full   = (occ == OWd'(Size));
    assign o_busy        = (state != IDLE);

`ifdef LPACCEL_WINSEQ_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || accept)
            o_stall_cnt <= '0;
        else if ((state == RUN) && !issue && !(&o_stall_cnt))
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/fifo_win_rdseq.md
Name: fifo_win_rdseq

Overview:
- Read sequencer that sits directly downstream of the line-buffer FIFO RAM.
- Drives the FIFO's i_read / i_pop / i_lastpix controls to stream K-tap sliding windows to the PE array.
- Tracks FIFO occupancy from observed upstream writes, replays a window R times for data reuse, and drains the row tail.
- Forwards read data through a 2-entry skid buffer with a rdy/ack handshake, because the FIFO's rvalid cannot be stalled.

Parameters:
- Size, 12, FIFO depth in entries; must equal the attached FIFO's Size.
- DWd, 16, bits per lane.
- InsNum, 16, lanes per entry.
- KMax, 7, maximum kernel taps.
- PixWd, 10, width of the pixels-per-row count.
- RepWd, 4, width of the repetition count.
- OWd, $clog2(Size+1), occupancy counter width (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cfg_rdy  in  1  config valid.
- o_cfg_ack  out  1  config accepted.
- i_cfg_k  in  $clog2(KMax+1)  taps per window, 1..KMax, must be <= Size.
- i_cfg_pix  in  PixWd  windows per row, >=1.
- i_cfg_rep  in  RepWd  passes per window, >=1.
- i_fifo_wr  in  1  upstream write event (FIFO i_write | i_dupWrite).
- o_fifo_full  out  1  occ==Size; upstream must not write while high.
- o_read  out  1  to FIFO i_read.
- o_pop  out  1  to FIFO i_pop.
- o_lastpix  out  1  to FIFO i_lastpix.
- i_rdata  in  InsNum*DWd  from FIFO o_rdata.
- i_rvalid  in  1  from FIFO o_rvalid.
- o_dst_rdy  out  1  output valid.
- i_dst_ack  in  1  output consumed.
- o_dst_data  out  InsNum*DWd  window tap data.
- o_dst_tap  out  $clog2(KMax)  tap index of o_dst_data.
- o_dst_lastpix  out  1  last tap of the last window of the row.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; occ, counters and buffer cleared. Reset mid-row abandons the row; the FIFO must be reset in the same cycle.
- Occupancy: i_fifo_wr adds 1; o_pop subtracts 1; both in one cycle leaves occ unchanged. i_fifo_wr while occ==Size is illegal (assertion).
- FSM IDLE:
  - o_cfg_ack=1 for one cycle when i_cfg_rdy.
  - Latch k/pix/rep; clear tap/rep/pix counters; go to RUN.
- FSM RUN, one tap per cycle:
  - Issue when occ>=k and credit<2. credit = buffer entries + read in flight (registered).
  - tap<k-1: o_read only; FIFO raddr increments.
  - tap==k-1 and rep<R-1: o_read+o_lastpix; raddr rewinds to start; rep++.
  - tap==k-1 and rep==R-1: o_read+o_pop+o_lastpix; start and raddr advance to start+1; pix++.
  - After the last window's final tap: go to DRAIN if k>1, else IDLE.
- FSM DRAIN:
  - Issue o_read+o_pop+o_lastpix k-1 times, one per cycle, with no credit needed.
  - Returned data is discarded: a discard flag is pipelined alongside i_rvalid.
  - Then go to IDLE.
- Output buffer:
  - Entry = {data, tap, lastpix}; captured on i_rvalid (non-discard), one cycle after o_read.
  - o_dst_rdy = buffer not empty.
  - Head is held stable until i_dst_ack, which pops the head that cycle.
  - Buffer never overflows, by the credit rule.
- o_lastpix is never asserted without o_read.
- Config in the same cycle as the last DRAIN issue is not accepted until the next cycle (IDLE).

Optional Feature:
- LPACCEL_WINSEQ_PERF_EN:
  - When defined, adds output o_stall_cnt (32 bits).
  - Counts RUN cycles where no tap was issued (occ<k or credit full).
  - Cleared on reset and on cfg accept; saturates at all-ones.
- Without the macro: no port, no counter logic.

Decomposition:
- Package fifo_win_pkg: FSM enum {IDLE, RUN, DRAIN}; struct for buffer entry {data, tap, lastpix}; cfg struct {k, pix, rep}.
- One sub-module fifo_win_skidbuf: a 2-entry rdy/ack buffer, parameterised on entry width, exposing its count for credit.

Test Plan:
- k=3, pix=4, rep=1; 6 writes preloaded; dst_ack tied 1 -> 12 taps with data order 0,1,2 / 1,2,3 / 2,3,4 / 3,4,5; 4 pops during RUN plus 2 in DRAIN; final occ=0; o_dst_lastpix only on the 12th tap; back to IDLE.
- k=3, pix=2, rep=2 -> taps 0,1,2,0,1,2,1,2,3,1,2,3; o_pop only on the 6th and 12th taps of RUN.
- Writes trickle 1 per 4 cycles -> no read issued while occ<k; output sequence is identical to the preloaded case.
- dst_ack held 0 for 10 cycles mid-row -> at most 2 entries buffered; o_dst_data stable; no data lost after ack resumes.
- k=1, pix=3 -> no DRAIN state entered; 3 pops total.
- i_rst asserted mid-RUN -> next cycle all outputs 0 and occ=0; a new config runs cleanly.
